// File: rtl/display_scan_driver.sv
// display_scan_driver
//
// Multiplexed six-digit seven-segment driver. Scans one digit of a BCD
// HH:MM:SS time onto a shared active-low segment bus. The six digit inputs
// are captured once per frame so a digit never changes part-way through a
// scan. The minutes or hours field can be blanked at a blink rate while
// that field is being set.
//
// Each digit slot lasts REFRESH_DIV cycles. The first cycle of every slot
// is a ghost-blank cycle with every output off, and the rest are lit. A
// frame is six slots. The blink phase toggles every BLINK_DIV frames.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   BLINK_DIV    complete frames per blink half-period (>= 1)
//
// Ports:
//   i_Clock       system clock
//   i_Reset       synchronous, active-high reset
//   i_Units_Sec   BCD seconds units (4)
//   i_Tens_Sec    seconds tens (3)
//   i_Units_Min   minutes units (4)
//   i_Tens_Min    minutes tens (3)
//   i_Units_Hour  hours units (4)
//   i_Tens_Hour   hours tens (2)
//   i_Blink_Min   blink digits 2-3, sampled live each cycle
//   i_Blink_Hour  blink digits 4-5, sampled live each cycle
//   o_Digit_Sel   one-hot-low digit enable (bit k = digit k, 0 = Units_Sec)
//   o_Segments    active-low {g,f,e,d,c,b,a}
//   o_Dp          active-low decimal point (lit on digits 2 and 4)
//
// All outputs are registered and show the scan state of the previous cycle.
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a zero hours-tens digit is shown
//                          blank in slot 5. The digit enable stays active.

module display_scan_driver #(
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV   = 64
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic [3:0] i_Units_Sec,
  input  logic [2:0] i_Tens_Sec,
  input  logic [3:0] i_Units_Min,
  input  logic [2:0] i_Tens_Min,
  input  logic [3:0] i_Units_Hour,
  input  logic [1:0] i_Tens_Hour,
  input  logic       i_Blink_Min,
  input  logic       i_Blink_Hour,
  output logic [5:0] o_Digit_Sel,
  output logic [6:0] o_Segments,
  output logic       o_Dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_DIV - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  // Scan state
  logic [PW-1:0] prescale;
  logic [2:0]    slot;
  logic [19:0]   snap;        // {th[1:0], uh[3:0], tm[2:0], um[3:0], ts[2:0], us[3:0]}
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic       frame_start;
  logic       slot_end;
  logic       frame_end;
  logic [3:0] cur_digit;
  logic [5:0] digit_sel_d;
  logic [6:0] segments_d;
  logic       dp_d;
  logic       field_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign frame_start = (prescale == '0) && (slot == 3'd0);
  assign slot_end    = (prescale == P_LAST);
  assign frame_end   = slot_end && (slot == 3'd5);

  // Snapshot digit for the current slot, zero-extended to 4 bits.
  always_comb begin
    cur_digit = 4'd0;
    case (slot)
      3'd0:    cur_digit = snap[3:0];
      3'd1:    cur_digit = {1'b0, snap[6:4]};
      3'd2:    cur_digit = snap[10:7];
      3'd3:    cur_digit = {1'b0, snap[13:11]};
      3'd4:    cur_digit = snap[17:14];
      default: cur_digit = {2'b00, snap[19:18]};
    endcase
  end

  // Output values for the current state. They are registered below.
  always_comb begin
    digit_sel_d = 6'b111111;
    segments_d  = 7'b1111111;
    dp_d        = 1'b1;
    field_blank = 1'b0;
    // The first cycle of each slot stays dark so the previous digit's
    // segments never ghost onto the newly enabled digit.
    if (prescale != '0) begin
      digit_sel_d = ~(6'b000001 << slot);
      segments_d  = seg_decode(cur_digit);
      dp_d        = !((slot == 3'd2) || (slot == 3'd4));
      if (blink_phase) begin
        if (i_Blink_Min && ((slot == 3'd2) || (slot == 3'd3)))
          field_blank = 1'b1;
        if (i_Blink_Hour && ((slot == 3'd4) || (slot == 3'd5)))
          field_blank = 1'b1;
      end
      if (LZ_BLANK && (slot == 3'd5) && (snap[19:18] == 2'd0))
        field_blank = 1'b1;
      if (field_blank)
        segments_d = 7'b1111111;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      prescale    <= '0;
      slot        <= 3'd0;
      snap        <= 20'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      o_Digit_Sel <= 6'b111111;
      o_Segments  <= 7'b1111111;
      o_Dp        <= 1'b1;
    end else begin
      if (frame_start)
        snap <= {i_Tens_Hour, i_Units_Hour, i_Tens_Min,
                 i_Units_Min, i_Tens_Sec, i_Units_Sec};

      if (slot_end) begin
        prescale <= '0;
        slot     <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      end else begin
        prescale <= prescale + PW'(1);
      end

      // Frames are counted on the transition into each new frame start.
      // This keeps the blink phase at 0 for the first BLINK_DIV frames
      // after reset.
      if (frame_end) begin
        if (frame_cnt == F_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      o_Digit_Sel <= digit_sel_d;
      o_Segments  <= segments_d;
      o_Dp        <= dp_d;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
module tb_display_scan_driver;

  localparam int RD = 4;
  localparam int BD = 2;
  localparam int FRAME = 6 * RD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] us, um, uh;
  logic [2:0] ts, tm;
  logic [1:0] th;
  logic       blink_min, blink_hour;
  logic [5:0] digit_sel;
  logic [6:0] segments;
  logic       dp;

  int errors = 0;
  int checks = 0;
  int s = 0;             // scan cycles since reset release (the state before the next edge)
  logic [3:0] m_dig[6];  // model snapshot: digit values captured at frame start
  logic [6:0] seg_tab[16];

  display_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_Units_Sec(us), .i_Tens_Sec(ts), .i_Units_Min(um),
    .i_Tens_Min(tm), .i_Units_Hour(uh), .i_Tens_Hour(th),
    .i_Blink_Min(blink_min), .i_Blink_Hour(blink_hour),
    .o_Digit_Sel(digit_sel), .o_Segments(segments), .o_Dp(dp)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (s=%0d): observed=%b expected=%b", tag, s, obs, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int sec);
    th = 2'(h / 10); uh = 4'(h % 10);
    tm = 3'(m / 10); um = 4'(m % 10);
    ts = 3'(sec / 10); us = 4'(sec % 10);
  endtask

  task automatic rand_digits();
    us = 4'($urandom_range(15)); ts = 3'($urandom_range(7));
    um = 4'($urandom_range(15)); tm = 3'($urandom_range(7));
    uh = 4'($urandom_range(15)); th = 2'($urandom_range(3));
  endtask

  // One cycle: predict from the scan position, clock, compare.
  task automatic step();
    int p, k, frame;
    logic       b;
    logic [5:0] e_sel;
    logic [6:0] e_seg;
    logic       e_dp;
    p = s % RD;
    k = (s / RD) % 6;
    frame = s / FRAME;
    b = ((frame / BD) % 2) == 1;
    if (p == 0 && k == 0) begin
      m_dig[0] = us; m_dig[1] = {1'b0, ts}; m_dig[2] = um;
      m_dig[3] = {1'b0, tm}; m_dig[4] = uh; m_dig[5] = {2'b00, th};
    end
    e_sel = 6'b111111; e_seg = 7'b1111111; e_dp = 1'b1;
    if (p != 0) begin
      e_sel = ~(6'b000001 << k);
      e_seg = seg_tab[m_dig[k]];
      e_dp  = (k == 2 || k == 4) ? 1'b0 : 1'b1;
      if (b && blink_min && (k == 2 || k == 3)) e_seg = 7'b1111111;
      if (b && blink_hour && (k == 4 || k == 5)) e_seg = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 5 && m_dig[5] == 4'd0) e_seg = 7'b1111111;
`endif
    end
    @(posedge clk); #1;
    check("digit_sel", {1'b0, digit_sel}, {1'b0, e_sel});
    check("segments", segments, e_seg);
    check("dp", {6'b0, dp}, {6'b0, e_dp});
    s++;
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_digit_sel", {1'b0, digit_sel}, 7'b0111111);
    check("rst_segments", segments, 7'b1111111);
    check("rst_dp", {6'b0, dp}, 7'b0000001);
    rst = 1'b0;
    s = 0;
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    for (int i = 0; i < 6; i++) m_dig[i] = 4'd0;
    rst = 1'b1; blink_min = 1'b0; blink_hour = 1'b0;
    rand_digits();

    // Reset held for several cycles with random inputs
    repeat (2) reset_cycle();
    rst = 1'b1;

    // Startup and scan of 12:34:56, frames 0-1
    set_time(12, 34, 56);
    reset_cycle();
    repeat (2 * FRAME) step();

    // Snapshot: change to 00:00:00 during slot 2 of frame 2
    repeat (2 * RD + 1) step();
    set_time(0, 0, 0);
    repeat (FRAME - (2 * RD + 1) + FRAME) step();

    // Blink hours across frames 4-9, including the blanked phase in frames 6-7
    set_time(12, 34, 56);
    blink_hour = 1'b1;
    repeat (2 * FRAME) step();
    // Minutes blink toggled at random together with hours blink
    for (int i = 0; i < 4 * FRAME; i++) begin
      blink_min = 1'($urandom_range(1));
      step();
    end
    blink_min = 1'b0; blink_hour = 1'b0;

    // Out-of-range minutes units
    um = 4'd12;
    repeat (FRAME) step();

    // Random digits, including out-of-range values, changed mid-frame
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ($urandom_range(7) == 0) rand_digits();
      if ($urandom_range(5) == 0) blink_min = ~blink_min;
      if ($urandom_range(5) == 0) blink_hour = ~blink_hour;
      step();
    end
    blink_min = 1'b0; blink_hour = 1'b0;

    // Reset mid-frame during slot 3, then restart with a zero hours tens digit
    while ((s % FRAME) != 3 * RD + 2) step();
    set_time(5, 34, 56);
    reset_cycle();
    repeat (2 * FRAME) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
